tone_channel_player: RTL and testbench
======================================

Name: tone_channel_player

Overview:
- Multi-channel square-wave note player for the MSS audio path.
- Holds a writable tone-to-prescale table, with reset contents equal to the current 16-entry note table.
- Per channel: accepts note commands (tone, octave shift, duration), generates the square wave, times the note, inserts an articulation gap, then reports completion.
- Sits between the game-logic sound requester and the audio DAC/mixer.

Parameters:
- NUM_CH, 2, number of independent channels.
- PRESCALE_W, 10, prescale/half-period width in bits.
- TONE_W, 4, tone index width; table depth is 2**TONE_W.
- DUR_W, 8, duration field width in ticks.
- TICK_DIV, 50000, clocks per duration tick.
- GAP_TICKS, 2, silent ticks after each timed note.
- RETRIGGER, 0, 1 allows a command to restart a busy channel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  TONE_W  table write index.
- tbl_data  in  PRESCALE_W  table write value.
- cmd_valid  in  1  note command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_ch  in  clog2(NUM_CH) (min 1)  target channel.
- cmd_stop  in  1  1 = stop target channel; other fields ignored.
- cmd_tone  in  TONE_W  table index.
- cmd_octave  in  2  prescale right-shift amount (0..3).
- cmd_dur  in  DUR_W  note length in ticks; 0 = sustain until stop.
- tone_out  out  NUM_CH  per-channel square wave.
- busy  out  NUM_CH  channel not IDLE.
- note_done  out  NUM_CH  1-cycle pulse on GAP->IDLE.
- mix_level  out  clog2(NUM_CH+1)  count of channels with tone_out high.

Behaviour:
- Reset (sync, wins over every other input):
  - all channels IDLE; tone_out, busy, note_done, mix_level = 0; tick counter = 0.
  - Table reloaded with, index 0..15: 1BB,18B,175,14C,128,117,0F9,0DD,2EA,2C0,299,273,250,22F,20F,1F2 (hex), zero-extended or truncated to PRESCALE_W.
  - For depth >16, the remaining entries are 0.
  - Reset mid-note stops the note without a done pulse.
- Tick generator: free-running counter 0..TICK_DIV-1; tick is a 1-cycle pulse when count == TICK_DIV-1. First tick after accept arrives within 1..TICK_DIV clocks; durations are accurate to -1 tick.
- Table write: tbl_we writes at the clock edge. A command accepted in the same cycle as a write to the same index uses the old value. A playing note is unaffected by table writes, because prescale is latched at accept.
- cmd_ready (combinational):
  - 1 if cmd_stop, or channel cmd_ch is IDLE, or RETRIGGER = 1; else 0.
  - cmd_ch >= NUM_CH: ready = 1, command dropped.
- Accept (valid&&ready):
  - Latch eff = table[cmd_tone] >> cmd_octave; if eff = 0, eff = 1.
  - Latch remaining = cmd_dur; clear the half-period counter; tone_out = 0; state becomes PLAY next cycle.
- Per-channel FSM:
  - IDLE: tone_out = 0. On accept -> PLAY.
  - PLAY: half-period counter increments each clock. When counter == eff: toggle tone_out, counter <- 0. Period = 2*(eff+1) clocks; first rising edge is eff+1 clocks after entering PLAY.
  - PLAY with cmd_dur != 0: on each tick, remaining decrements. On a tick with remaining == 1 -> GAP (or IDLE with note_done if GAP_TICKS = 0).
  - GAP: tone_out forced 0; counts GAP_TICKS ticks, then -> IDLE with note_done pulsed in the transition cycle.
  - Stop command (any state): -> IDLE next cycle, tone_out = 0, no note_done.
  - Retrigger accept in PLAY/GAP: restarts as a fresh accept, no note_done for the aborted note.
- Stop and tick on the same cycle: stop wins. note_done and a new accept on the same channel in the same cycle: the accept is honoured and the channel enters PLAY.
- mix_level is the registered popcount of tone_out, one cycle behind tone_out.
- Channels are fully independent; only one command per cycle.

Test Plan:
- Reset, then read back via play: cmd ch0 tone 0 oct 0 dur 0 -> tone_out[0] half-period 444 clocks (eff 0x1BB = 443), period 888; busy[0] = 1.
- Octave shift: tone 8 (0x2EA = 746) oct 2 -> eff 186, period 374 clocks. Write table[3] = 0 then play with oct 0 -> eff clamped to 1, period 4.
- Duration (TICK_DIV = 100, GAP_TICKS = 2): dur 3 -> tone active 201..300 clocks, then 200 clocks silent, note_done 1-cycle pulse, busy drops same cycle.
- Handshake, RETRIGGER = 0: second cmd to busy ch0 -> cmd_ready = 0. Stop to ch0 -> accepted, tone_out[0] = 0 and busy[0] = 0 next cycle, no note_done. Cmd to ch1 while ch0 busy -> accepted.
- Same-cycle events: table write to index 5 with accept of tone 5 -> old value 0x117 used. Stop coincident with final tick -> no note_done.
- Two channels with eff 1 and eff 3 -> mix_level follows the popcount of tone_out delayed 1 cycle, values in 0..2. Reset asserted mid-note -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tone_channel_player.sv
// Multi-channel square-wave note player: a writable tone->prescale table feeds
// independent channels that play, time and gap notes, then pulse note_done.
module tone_channel_player #(
    parameter int NUM_CH     = 2,
    parameter int PRESCALE_W = 10,
    parameter int TONE_W     = 4,
    parameter int DUR_W      = 8,
    parameter int TICK_DIV   = 50000,
    parameter int GAP_TICKS  = 2,
    parameter int RETRIGGER  = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int MIX_W     = $clog2(NUM_CH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tbl_we,
    input  logic [TONE_W-1:0]     tbl_addr,
    input  logic [PRESCALE_W-1:0] tbl_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic                  cmd_stop,
    input  logic [TONE_W-1:0]     cmd_tone,
    input  logic [1:0]            cmd_octave,
    input  logic [DUR_W-1:0]      cmd_dur,
    output logic [NUM_CH-1:0]     tone_out,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     note_done,
    output logic [MIX_W-1:0]      mix_level
);

    localparam int DEPTH  = 2 ** TONE_W;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} ch_state_t;

    function automatic logic [PRESCALE_W-1:0] init_val(input int idx);
        logic [11:0] v;
        case (idx)
            0: v = 12'h1BB;  1: v = 12'h18B;  2: v = 12'h175;  3: v = 12'h14C;
            4: v = 12'h128;  5: v = 12'h117;  6: v = 12'h0F9;  7: v = 12'h0DD;
            8: v = 12'h2EA;  9: v = 12'h2C0; 10: v = 12'h299; 11: v = 12'h273;
            12: v = 12'h250; 13: v = 12'h22F; 14: v = 12'h20F; 15: v = 12'h1F2;
            default: v = 12'h000;
        endcase
        return PRESCALE_W'(v);
    endfunction

    logic [PRESCALE_W-1:0] tbl [DEPTH];
    logic [TICK_W-1:0]     tick_cnt;
    logic                  tick;
    logic [PRESCALE_W-1:0] eff_raw, eff_new;
    logic [NUM_CH-1:0]     idle_v;
    logic                  sel_idle, ch_valid;
    logic [MIX_W-1:0]      pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= init_val(i);
        end else if (tbl_we) begin
            tbl[tbl_addr] <= tbl_data;
        end
    end

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + TICK_W'(1);
    end

    // The table is read before this edge's write lands, so a same-cycle write is not seen.
    assign eff_raw = tbl[cmd_tone] >> cmd_octave;
    assign eff_new = (eff_raw == '0) ? PRESCALE_W'(1) : eff_raw;

    always_comb begin
        sel_idle = 1'b0;
        ch_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
                ch_valid = 1'b1;
                sel_idle = idle_v[i];
            end
        end
    end

    // Handshake: a command transfers on a cycle with cmd_valid && cmd_ready.
    assign cmd_ready = !ch_valid || cmd_stop || sel_idle || (RETRIGGER != 0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t             state, next_state;
        logic                  acc, acc_stop, acc_play, done_set, done_q, tone_q;
        logic                  ch_tone, ch_busy;
        logic [PRESCALE_W-1:0] eff, half_cnt;
        logic [DUR_W-1:0]      remaining;
        logic [GAP_W-1:0]      gap_cnt;

        assign acc      = cmd_valid && cmd_ready && (cmd_ch == CH_W'(c));
        assign acc_stop = acc && cmd_stop;
        assign acc_play = acc && !cmd_stop;

        always_ff @(posedge clk) begin
            if (reset) state <= IDLE;
            else       state <= next_state;
        end

        always_comb begin
            next_state = state;
            done_set   = 1'b0;
            if (acc_stop) begin
                next_state = IDLE;
            end else if (acc_play) begin
                next_state = PLAY;
            end else begin
                case (state)
                    PLAY: if (tick && remaining == DUR_W'(1)) begin
                        if (GAP_TICKS == 0) begin
                            next_state = IDLE;
                            done_set   = 1'b1;
                        end else begin
                            next_state = GAP;
                        end
                    end
                    GAP: if (tick && gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                        next_state = IDLE;
                        done_set   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end

        always_comb begin
            ch_tone = (state == PLAY) && tone_q;
            ch_busy = (state != IDLE);
        end

        // remaining == 0 means sustain; a timed note leaves PLAY before reaching 0.
        always_ff @(posedge clk) begin
            if (reset) begin
                eff       <= '0;
                half_cnt  <= '0;
                remaining <= '0;
                gap_cnt   <= '0;
                tone_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                done_q <= done_set;
                if (acc_play) begin
                    eff       <= eff_new;
                    remaining <= cmd_dur;
                    half_cnt  <= '0;
                    gap_cnt   <= '0;
                    tone_q    <= 1'b0;
                end else if (state == PLAY && next_state == PLAY) begin
                    if (half_cnt == eff) begin
                        half_cnt <= '0;
                        tone_q   <= ~tone_q;
                    end else begin
                        half_cnt <= half_cnt + PRESCALE_W'(1);
                    end
                    if (tick && remaining != '0) remaining <= remaining - DUR_W'(1);
                end else begin
                    half_cnt <= '0;
                    tone_q   <= 1'b0;
                    if (state == GAP && tick) gap_cnt <= gap_cnt + GAP_W'(1);
                    else if (state != GAP)    gap_cnt <= '0;
                end
            end
        end

        assign idle_v[c]    = (state == IDLE);
        assign tone_out[c]  = ch_tone;
        assign busy[c]      = ch_busy;
        assign note_done[c] = done_q;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) pop = pop + MIX_W'(tone_out[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) mix_level <= '0;
        else       mix_level <= pop;
    end

endmodule

// File: tb/tb_tone_channel_player.sv
// Bench for tone_channel_player: an event timeline per note is predicted from the
// tick/period arithmetic and matched against tone edges, note_done and busy.
module tb_tone_channel_player;
    localparam int NUM_CH = 2;
    localparam int TD     = 100;
    localparam int GAPT   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = '0;
    logic [9:0] tbl_data = '0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [0:0] cmd_ch = '0;
    logic       cmd_stop = 1'b0;
    logic [3:0] cmd_tone = '0;
    logic [1:0] cmd_octave = '0;
    logic [7:0] cmd_dur = '0;
    logic [1:0] tone_out, busy, note_done, mix_level;

    tone_channel_player #(
        .NUM_CH(NUM_CH), .PRESCALE_W(10), .TONE_W(4), .DUR_W(8),
        .TICK_DIV(TD), .GAP_TICKS(GAPT), .RETRIGGER(0)
    ) dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_stop(cmd_stop),
        .cmd_tone(cmd_tone), .cmd_octave(cmd_octave), .cmd_dur(cmd_dur),
        .tone_out(tone_out), .busy(busy), .note_done(note_done), .mix_level(mix_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int rel0 = 0;
    bit mon_en = 1'b0;
    int init_tbl[16] = '{'h1BB, 'h18B, 'h175, 'h14C, 'h128, 'h117, 'h0F9, 'h0DD,
                         'h2EA, 'h2C0, 'h299, 'h273, 'h250, 'h22F, 'h20F, 'h1F2};
    int mtbl[16];
    int note_a[NUM_CH], note_e[NUM_CH], note_end[NUM_CH], note_fall[NUM_CH];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    function automatic bit model_busy(input int ch, input int n);
        return (n >= note_a[ch]) && (n < note_fall[ch]);
    endfunction

    function automatic int model_tone(input int ch, input int n);
        if (n <= note_a[ch] || n >= note_end[ch]) return 0;
        return ((n - note_a[ch]) / (note_e[ch] + 1)) % 2;
    endfunction

    function automatic int next_tick_after(input int n);
        int r;
        r = (n + 1 - rel0) % TD;
        return n + 1 + (TD - 1 - r);
    endfunction

    task automatic push_ev(input int ch, input int n, input int kind);
        logic [31:0] w;
        w = {n[29:0], kind[1:0]};
        if (ch == 0) exp_q0.push_back(w);
        else         exp_q1.push_back(w);
    endtask

    // kinds: 0 tone edge, 1 note_done, 2 busy rise, 3 busy fall
    task automatic check_event(input int ch, input int n, input int kind);
        logic [31:0] w, got;
        int sz;
        got = {n[29:0], kind[1:0]};
        sz = (ch == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL unexpected_event ch%0d: got edge %0d kind %0d, expected none", ch, n, kind);
        end else begin
            w = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (w != got) begin
                errors++;
                $display("FAIL event ch%0d: got edge %0d kind %0d, expected edge %0d kind %0d",
                         ch, n, kind, w[31:2], w[1:0]);
            end
        end
    endtask

    logic [1:0] prev_tone = '0;
    logic [1:0] prev_busy = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (tone_out[c] != prev_tone[c]) check_event(c, cyc, 0);
                if (note_done[c])                check_event(c, cyc, 1);
                if (busy[c] && !prev_busy[c])    check_event(c, cyc, 2);
                if (!busy[c] && prev_busy[c])    check_event(c, cyc, 3);
            end
            check("mix_level", int'(mix_level), model_tone(0, cyc - 1) + model_tone(1, cyc - 1));
        end
        prev_tone <= tone_out;
        prev_busy <= busy;
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) mtbl[i] = init_tbl[i] & 'h3FF;
        for (int c = 0; c < NUM_CH; c++) begin
            note_a[c] = 0; note_e[c] = 1; note_end[c] = 0; note_fall[c] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_tone_out", int'(tone_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_note_done", int'(note_done), 0);
        check("reset_mix_level", int'(mix_level), 0);
        reset = 1'b0;
        clear_model();
        rel0 = cyc + 1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic wait_until(input int e);
        while (cyc < e - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic tbl_write(input int addr, input int data);
        tbl_we = 1'b1; tbl_addr = addr[3:0]; tbl_data = data[9:0];
        @(posedge clk); #1;
        mtbl[addr] = data;
        tbl_we = 1'b0;
    endtask

    task automatic send(input int ch, input bit stop, input int tone, input int oct, input int dur,
                        input bit we, input int waddr, input int wdata,
                        output int acc_edge, output bit acc, output int eff);
        bit exp_ready;
        cmd_valid = 1'b1; cmd_ch = ch[0:0]; cmd_stop = stop; cmd_tone = tone[3:0];
        cmd_octave = oct[1:0]; cmd_dur = dur[7:0];
        tbl_we = we; tbl_addr = waddr[3:0]; tbl_data = wdata[9:0];
        exp_ready = stop || !model_busy(ch, cyc);
        eff = mtbl[tone] >> oct;
        if (eff == 0) eff = 1;
        #1;
        check("cmd_ready", int'(cmd_ready), int'(exp_ready));
        @(posedge clk); #1;
        acc_edge = cyc;
        acc = exp_ready;
        if (we) mtbl[waddr] = wdata;
        cmd_valid = 1'b0; cmd_stop = 1'b0; tbl_we = 1'b0;
    endtask

    // stop_at > 0: the note is cut by a stop accepted at that edge (no done pulse).
    task automatic play(input int ch, input int tone, input int oct, input int dur, input int stop_at,
                        input bit we, input int waddr, input int wdata);
        int a, e, t_last, t_end, t_fall, tog;
        bit acc, done;
        send(ch, 1'b0, tone, oct, dur, we, waddr, wdata, a, acc, e);
        if (!acc) return;
        t_last = (dur > 0) ? next_tick_after(a) + (dur - 1) * TD : 0;
        if (stop_at > 0) begin
            t_end = stop_at; t_fall = stop_at; done = 1'b0;
        end else begin
            t_end = t_last; t_fall = t_last + GAPT * TD; done = 1'b1;
        end
        note_a[ch] = a; note_e[ch] = e; note_end[ch] = t_end; note_fall[ch] = t_fall;
        push_ev(ch, a, 2);
        tog = 0;
        for (int n = a + e + 1; n < t_end; n += e + 1) begin
            push_ev(ch, n, 0);
            tog++;
        end
        if (tog % 2 == 1) push_ev(ch, t_end, 0);
        if (done) push_ev(ch, t_fall, 1);
        push_ev(ch, t_fall, 3);
    endtask

    task automatic stop_ch(input int ch, input int at);
        int a, e;
        bit acc;
        wait_until(at);
        send(ch, 1'b1, 0, 0, 0, 1'b0, 0, 0, a, acc, e);
    endtask

    task automatic drain();
        int m;
        m = (note_fall[0] > note_fall[1]) ? note_fall[0] : note_fall[1];
        wait_until(m + 2);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s0, s1, t_last, f1, ch, tn, oc, du, gap;
        bit w;
        clear_model();
        do_reset();

        // Sustained notes on both channels, reject on busy ch0, then stops.
        s0 = cyc + 1 + 1500;
        play(0, 0, 0, 0, s0, 1'b0, 0, 0);
        s1 = cyc + 1 + 1000;
        play(1, 8, 2, 0, s1, 1'b0, 0, 0);
        play(0, 2, 0, 5, 0, 1'b0, 0, 0);
        stop_ch(1, s1);
        stop_ch(0, s0);
        drain();

        // Clamped eff 1 on ch0 alongside eff 3 on ch1.
        tbl_write(3, 0);
        tbl_write(9, 12);
        play(0, 3, 0, 2, 0, 1'b0, 0, 0);
        play(1, 9, 2, 2, 0, 1'b0, 0, 0);
        drain();

        // Same-cycle write to index 5 while accepting tone 5: old value applies.
        play(1, 5, 0, 3, 0, 1'b1, 5, 'h050);
        drain();
        play(0, 5, 0, 1, 0, 1'b0, 0, 0);
        drain();

        // Stop landing on the final tick suppresses note_done.
        t_last = next_tick_after(cyc + 1) + TD;
        play(0, 1, 0, 2, t_last, 1'b0, 0, 0);
        stop_ch(0, t_last);
        drain();

        // New accept during the note_done cycle.
        play(1, 2, 3, 1, 0, 1'b0, 0, 0);
        f1 = note_fall[1];
        wait_until(f1 + 1);
        play(1, 4, 1, 1, 0, 1'b0, 0, 0);
        drain();

        for (int k = 0; k < 14; k++) begin
            ch = $urandom_range(0, 1);
            tn = $urandom_range(0, 15);
            oc = $urandom_range(0, 3);
            du = $urandom_range(1, 3);
            w  = ($urandom_range(0, 3) == 0);
            if (model_busy(ch, cyc)) begin
                play(ch, tn, oc, du, 0, 1'b0, 0, 0);
                wait_until(note_fall[ch] + 1);
            end
            gap = $urandom_range(0, 20);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            play(ch, tn, oc, du, 0, w, $urandom_range(0, 15), $urandom_range(0, 1023));
        end
        drain();
        check("queue_empty_ch0", exp_q0.size(), 0);
        check("queue_empty_ch1", exp_q1.size(), 0);

        // Reset mid-note, then confirm the table is reloaded.
        play(0, 0, 0, 0, cyc + 1 + 50000, 1'b0, 0, 0);
        play(1, 6, 1, 2, 0, 1'b0, 0, 0);
        repeat (300) begin
            @(posedge clk); #1;
        end
        do_reset();
        play(0, 3, 0, 1, 0, 1'b0, 0, 0);
        play(1, 5, 1, 1, 0, 1'b0, 0, 0);
        drain();
        check("queue_empty_ch0_end", exp_q0.size(), 0);
        check("queue_empty_ch1_end", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
